z80_bus_responder: RTL and testbench
====================================

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MEM_WAIT, 0, extra wait cycles inserted per memory read, range 0..7.
- IO_WAIT, 1, extra wait cycles inserted per I/O read or write, range 0..7.
- IRQ_VECTOR, 8'hFF, byte driven on di during interrupt acknowledge.
- IO_BASE, 8'h10, base address of 4 I/O registers.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- A  in  16  CPU address bus.
- dout  in  8  CPU write data.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes.
- di  out  8  read data to CPU (registered).
- wait_n  out  1  wait request to CPU.
- int_n  out  1  interrupt request to CPU.
- irq  in  1  level interrupt source.
- mem_req  out  1  sync-RAM read strobe.
- mem_we  out  1  sync-RAM write strobe.
- mem_addr  out  16  sync-RAM address.
- mem_wdata  out  8  sync-RAM write data.
- mem_rdata  in  8  sync-RAM read data, valid 1 clk after mem_req.
- io_regs  out  32  the 4 I/O registers, concatenated {reg3,reg2,reg1,reg0}.

Function
REQ-003 The FSM SHALL have states IDLE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK, WAITCNT and DONE.
REQ-004 IDLE SHALL select, in priority order:
- INTACK when m1_n=0 and iorq_n=0;
- MEM_RD when mreq_n=0, rd_n=0 and rfsh_n=1;
- MEM_WR when mreq_n=0 and wr_n=0;
- IO_RD when iorq_n=0, m1_n=1 and rd_n=0;
- IO_WR when iorq_n=0, m1_n=1 and wr_n=0.
REQ-005 Refresh cycles (rfsh_n=0) SHALL be ignored: no mem_req, no mem_we, and no change to di.
REQ-006 MEM_RD SHALL pulse mem_req for one clk with mem_addr=A, and latch mem_rdata into di on the following clk.
REQ-007 MEM_WR SHALL pulse mem_we for exactly one clk per bus cycle, with mem_addr=A and mem_wdata=dout.
REQ-008 IO_RD SHALL drive di with io_reg[A[1:0]] when A[7:2]=IO_BASE[7:2], and 8'hFF otherwise.
REQ-009 IO_WR SHALL write dout into io_reg[A[1:0]] only when A[7:2]=IO_BASE[7:2], once per bus cycle.
REQ-010 INTACK SHALL drive di=IRQ_VECTOR and clear the pending interrupt.
REQ-011 WAITCNT SHALL hold wait_n=0 while a 3-bit counter loaded with MEM_WAIT or IO_WAIT counts down; when the count is 0, this state SHALL be skipped.
REQ-012 wait_n SHALL go low combinationally in the same clk the cycle is detected whenever the relevant wait count is nonzero, and SHALL return high on the clk the counter reaches 0.
REQ-013 DONE SHALL hold until mreq_n=1 and iorq_n=1, then return to IDLE; a cycle SHALL never be serviced twice.
REQ-014 int_n SHALL go low 1 clk after irq rises, and SHALL stay low until the INTACK state is entered.
REQ-015 If irq is still high after INTACK, int_n SHALL reassert only after DONE exits.
REQ-016 di SHALL hold its last value outside read and INTACK cycles.

Reset
REQ-017 Reset SHALL force the state to IDLE and set:
- wait_n=1, int_n=1, mem_req=0, mem_we=0;
- di=8'hFF, mem_addr=0, mem_wdata=0;
- io_regs=0, wait counter=0, pending interrupt=0.
REQ-018 Reset asserted mid-cycle SHALL abort the cycle with no further mem_we pulse; after release, the FSM SHALL wait for strobes idle before decoding.

Structure
REQ-019 A shared package z80_bus_pkg SHALL hold the state enum typedef, the cycle-type enum, and the constants DEFAULT_IRQ_VECTOR and DEFAULT_IO_BASE.
REQ-020 One sub-module, z80_wait_counter (load, count, zero flag), SHALL implement WAITCNT.

Verification
REQ-021 Memory read: mem[0000]=07, MEM_WAIT=0, read at A=0000 -> one mem_req pulse; di=07 two clks after mreq_n&rd_n fall; wait_n stays 1.
REQ-022 Memory write: A=1234, dout=5A, wr_n held low 3 clks -> exactly one mem_we, mem_addr=1234, mem_wdata=5A.
REQ-023 I/O round trip: IO_WAIT=2, OUT (12h),A5 then IN (12h) -> io_regs[23:16]=A5; IN returns A5; wait_n low exactly 2 clks on each cycle; IN (40h) returns FF.
REQ-024 Interrupt: irq=1 -> int_n=0 next clk; m1_n&iorq_n low -> di=FF and int_n=1.
REQ-025 Refresh cycle: mreq_n=0, rfsh_n=0 -> no mem_req, no mem_we, di unchanged.
REQ-026 Reset mid-cycle: reset during MEM_WR wait -> no mem_we pulse, and all outputs equal the REQ-017 values.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus responder: FSM states, decoded
// bus-cycle kinds and the default interrupt vector / I/O base address.
package z80_bus_pkg;

  localparam int unsigned WAIT_W = 3;

  localparam logic [7:0] DEFAULT_IRQ_VECTOR = 8'hFF;
  localparam logic [7:0] DEFAULT_IO_BASE    = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RD,
    S_MEM_WR,
    S_IO_RD,
    S_IO_WR,
    S_INTACK,
    S_WAITCNT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTACK
  } cyc_t;

  // Access state that services a given decoded cycle.
  function automatic state_t cyc_state(input cyc_t c);
    state_t s;
    case (c)
      CYC_MEM_RD: s = S_MEM_RD;
      CYC_MEM_WR: s = S_MEM_WR;
      CYC_IO_RD:  s = S_IO_RD;
      CYC_IO_WR:  s = S_IO_WR;
      CYC_INTACK: s = S_INTACK;
      default:    s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/z80_wait_counter.sv
// Loadable 3-bit down-counter for wait-state insertion. o_zero also reports a
// count that reaches zero on this clock, so wait_n releases in that same clock.
module z80_wait_counter
  import z80_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_count,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0) || (i_count && (r_cnt == WAIT_W'(1)));

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus-cycle responder: decodes CPU strobes, bridges memory cycles to a
// synchronous RAM, serves four I/O registers and the interrupt acknowledge.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned IO_WAIT    = 1,
  parameter logic [7:0]  IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
  parameter logic [7:0]  IO_BASE    = DEFAULT_IO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] io_regs
);

  localparam logic [WAIT_W-1:0] MEM_WAIT_V = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_V  = WAIT_W'(IO_WAIT);

  state_t            r_state, w_state_next;
  cyc_t              r_cyc, w_cyc;
  logic              r_armed;
  logic [WAIT_W-1:0] w_wait_val;
  logic              w_wait_load, w_wait_zero;

  logic [7:0]        r_di, w_di_d;
  logic              r_mem_req, w_mem_req_d;
  logic              r_mem_we, w_mem_we_d;
  logic [15:0]       r_mem_addr, w_mem_addr_d;
  logic [7:0]        r_mem_wdata, w_mem_wdata_d;
  logic [3:0][7:0]   r_io_regs, w_io_regs_d;
  logic              r_rd_pend;
  logic              r_irq_pend, r_irq_block;
  logic              w_io_hit;

  // Strobe decode in priority order; suppressed until the bus has gone idle after reset.
  always_comb begin
    w_cyc = CYC_NONE;
    if (r_armed) begin
      if (!m1_n && !iorq_n)                 w_cyc = CYC_INTACK;
      else if (!mreq_n && !rd_n && rfsh_n)  w_cyc = CYC_MEM_RD;
      else if (!mreq_n && !wr_n && rfsh_n)  w_cyc = CYC_MEM_WR;
      else if (!iorq_n && m1_n && !rd_n)    w_cyc = CYC_IO_RD;
      else if (!iorq_n && m1_n && !wr_n)    w_cyc = CYC_IO_WR;
    end
  end

  // MEM_WAIT stretches memory writes as well as reads.
  always_comb begin
    w_wait_val = '0;
    case (w_cyc)
      CYC_MEM_RD, CYC_MEM_WR: w_wait_val = MEM_WAIT_V;
      CYC_IO_RD, CYC_IO_WR:   w_wait_val = IO_WAIT_V;
      default:                w_wait_val = '0;
    endcase
  end

  assign w_wait_load = (r_state == S_IDLE) && (w_cyc != CYC_NONE) && (w_wait_val != '0);

  z80_wait_counter u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_wait_load),
    .i_load_val(w_wait_val),
    .i_count   (r_state == S_WAITCNT),
    .o_zero    (w_wait_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wait_load)            w_state_next = S_WAITCNT;
        else if (w_cyc != CYC_NONE) w_state_next = cyc_state(w_cyc);
      end
      S_WAITCNT: if (w_wait_zero) w_state_next = cyc_state(r_cyc);
      S_MEM_RD, S_MEM_WR, S_IO_RD, S_IO_WR, S_INTACK: w_state_next = S_DONE;
      S_DONE:    if (mreq_n && iorq_n) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_io_hit = (A[7:2] == IO_BASE[7:2]);

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    w_mem_req_d   = (w_state_next == S_MEM_RD);
    w_mem_we_d    = (w_state_next == S_MEM_WR);
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_di_d        = r_di;
    w_io_regs_d   = r_io_regs;
    if (w_mem_req_d || w_mem_we_d) w_mem_addr_d = A;
    if (w_mem_we_d) w_mem_wdata_d = dout;
    if (r_rd_pend) w_di_d = mem_rdata;
    if (w_state_next == S_IO_RD) w_di_d = w_io_hit ? r_io_regs[A[1:0]] : 8'hFF;
    if (w_state_next == S_INTACK) w_di_d = IRQ_VECTOR;
    if ((w_state_next == S_IO_WR) && w_io_hit) w_io_regs_d[A[1:0]] = dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_di        <= 8'hFF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_io_regs   <= '0;
      r_rd_pend   <= 1'b0;
      r_cyc       <= CYC_NONE;
      r_armed     <= 1'b0;
      r_irq_pend  <= 1'b0;
      r_irq_block <= 1'b0;
    end else begin
      r_di        <= w_di_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_io_regs   <= w_io_regs_d;
      r_rd_pend   <= r_mem_req;
      r_armed     <= r_armed | (mreq_n & iorq_n);
      if ((r_state == S_IDLE) && (w_cyc != CYC_NONE)) r_cyc <= w_cyc;
      // Acknowledge clears the request; re-arming waits until the acknowledge cycle ends.
      if (w_state_next == S_INTACK) begin
        r_irq_pend  <= 1'b0;
        r_irq_block <= 1'b1;
      end else begin
        if (irq && !r_irq_block) r_irq_pend <= 1'b1;
        if ((r_state == S_DONE) && (w_state_next == S_IDLE)) r_irq_block <= 1'b0;
      end
    end
  end

  assign di        = r_di;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign io_regs   = r_io_regs;
  assign int_n     = ~r_irq_pend;
  assign wait_n    = ~(w_wait_load | ((r_state == S_WAITCNT) & ~w_wait_zero));

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench: one responder with MEM_WAIT=0/IO_WAIT=2 plus a second with
// MEM_WAIT=3/IO_WAIT=1 used for the mid-cycle reset scenario.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, irq;

  logic [7:0]  di, mem_wdata, mem_rdata;
  logic        wait_n, int_n, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] io_regs;

  logic [7:0]  w_di, w_mem_wdata;
  logic        w_wait_n, w_int_n, w_mem_req, w_mem_we;
  logic [15:0] w_mem_addr;
  logic [31:0] w_io_regs;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_err = 0;
  int n_req = 0, n_we = 0, n_wait = 0, n_we_w = 0, n_wait_w = 0;
  int b_req, b_we, b_wait, b_we_w, b_wait_w;

  always #5 clk = ~clk;

  z80_bus_responder #(.MEM_WAIT(0), .IO_WAIT(2)) dut (
    .clk(clk), .reset(reset), .A(A), .dout(dout),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .di(di), .wait_n(wait_n), .int_n(int_n), .irq(irq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_regs(io_regs)
  );

  z80_bus_responder #(.MEM_WAIT(3), .IO_WAIT(1)) dut_w (
    .clk(clk), .reset(reset), .A(A), .dout(dout),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .di(w_di), .wait_n(w_wait_n), .int_n(w_int_n), .irq(irq),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_rdata(8'h00), .io_regs(w_io_regs)
  );

  // Synchronous RAM: read data one clock after mem_req; location 0 preloaded during reset.
  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= 8'h07;
    end else begin
      if (mem_req) mem_rdata <= mem[mem_addr];
      if (mem_we)  mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_req)   n_req++;
    if (mem_we)    n_we++;
    if (!wait_n)   n_wait++;
    if (w_mem_we)  n_we_w++;
    if (!w_wait_n) n_wait_w++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_req = n_req; b_we = n_we; b_wait = n_wait; b_we_w = n_we_w; b_wait_w = n_wait_w;
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One I/O cycle on the IO_WAIT=2 responder; strobes held long enough to finish.
  task automatic io_cycle(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [7:0] data);
    snap();
    A = addr; dout = data; iorq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    #1;
    check_eq({tag, "_wait_now"}, 32'(wait_n), 32'd0);
    tick(5);
    bus_idle();
    tick(2);
    check_eq({tag, "_wait_clks"}, 32'(n_wait - b_wait), 32'd2);
  endtask

  initial begin
    reset = 1'b1; A = '0; dout = '0; irq = 1'b0;
    bus_idle();
    tick(3);
    check_eq("rst_di", 32'(di), 32'hFF);
    check_eq("rst_ctl", {28'd0, wait_n, int_n, mem_req, mem_we}, 32'hC);
    check_eq("rst_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'h0);
    check_eq("rst_io", io_regs, 32'h0);
    reset = 1'b0;
    tick(2);

    // Memory read, no wait states
    snap();
    A = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
    tick(1);
    check_eq("rd_req", 32'(mem_req), 32'd1);
    check_eq("rd_addr", 32'(mem_addr), 32'h0000);
    tick(1);
    check_eq("rd_req_off", 32'(mem_req), 32'd0);
    check_eq("rd_di_early", 32'(di), 32'hFF);
    tick(1);
    check_eq("rd_di", 32'(di), 32'h07);
    bus_idle();
    tick(2);
    check_eq("rd_req_cnt", 32'(n_req - b_req), 32'd1);
    check_eq("rd_wait", 32'(n_wait - b_wait), 32'd0);

    // Refresh cycle must be ignored even with rd_n low
    snap();
    A = 16'h0042; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    tick(3);
    bus_idle();
    tick(2);
    check_eq("rfsh_req", 32'(n_req - b_req), 32'd0);
    check_eq("rfsh_we", 32'(n_we - b_we), 32'd0);
    check_eq("rfsh_di", 32'(di), 32'h07);

    // Memory write held for three clocks
    snap();
    A = 16'h1234; dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
    tick(1);
    check_eq("wr_we", 32'(mem_we), 32'd1);
    check_eq("wr_addr", 32'(mem_addr), 32'h1234);
    check_eq("wr_wdata", 32'(mem_wdata), 32'h5A);
    tick(2);
    bus_idle();
    tick(2);
    check_eq("wr_we_cnt", 32'(n_we - b_we), 32'd1);
    check_eq("wr_ram", 32'(mem[16'h1234]), 32'h5A);
    check_eq("wr_di_hold", 32'(di), 32'h07);

    // I/O round trip through the register file
    io_cycle("out12", 1'b1, 16'hA512, 8'hA5);
    check_eq("out12_reg", io_regs, 32'h00A5_0000);
    io_cycle("out22", 1'b1, 16'h0022, 8'h77);
    check_eq("out22_miss", io_regs, 32'h00A5_0000);
    io_cycle("out13", 1'b1, 16'h0013, 8'h3C);
    check_eq("out13_reg", io_regs, 32'h3CA5_0000);
    io_cycle("in12", 1'b0, 16'h0012, 8'h00);
    check_eq("in12_di", 32'(di), 32'hA5);
    io_cycle("in40", 1'b0, 16'h0040, 8'h00);
    check_eq("in40_di", 32'(di), 32'hFF);
    io_cycle("in11", 1'b0, 16'h0011, 8'h00);
    check_eq("in11_di", 32'(di), 32'h00);

    // Interrupt request and acknowledge
    irq = 1'b1;
    #1;
    check_eq("irq_int_pre", 32'(int_n), 32'd1);
    tick(1);
    check_eq("irq_int_low", 32'(int_n), 32'd0);
    tick(2);
    check_eq("irq_int_hold", 32'(int_n), 32'd0);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    check_eq("ack_di", 32'(di), 32'hFF);
    check_eq("ack_int", 32'(int_n), 32'd1);
    tick(2);
    check_eq("ack_int_blk", 32'(int_n), 32'd1);
    bus_idle();
    tick(1);
    check_eq("ack_int_exit", 32'(int_n), 32'd1);
    tick(1);
    check_eq("irq_reassert", 32'(int_n), 32'd0);
    irq = 1'b0;
    tick(2);
    check_eq("irq_latched", 32'(int_n), 32'd0);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(2);
    bus_idle();
    tick(3);
    check_eq("ack2_int", 32'(int_n), 32'd1);

    // Reset in the middle of a waited memory write on the MEM_WAIT=3 responder
    snap();
    A = 16'h4321; dout = 8'hC3; mreq_n = 1'b0; wr_n = 1'b0;
    tick(1);
    check_eq("rmid_wait0", 32'(w_wait_n), 32'd0);
    tick(1);
    check_eq("rmid_wait1", 32'(w_wait_n), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rmid_wait_rst", 32'(w_wait_n), 32'd1);
    tick(2);
    reset = 1'b0;
    snap();
    tick(2);
    check_eq("rmid_noarm_w", 32'(w_wait_n), 32'd1);
    check_eq("rmid_noarm_we", 32'(n_we - b_we), 32'd0);
    bus_idle();
    tick(3);
    check_eq("rmid_we_w", 32'(n_we_w - b_we_w), 32'd0);
    check_eq("rmid_di", 32'(w_di), 32'hFF);
    check_eq("rmid_ctl", {28'd0, w_wait_n, w_int_n, w_mem_req, w_mem_we}, 32'hC);
    check_eq("rmid_addr", 32'(w_mem_addr), 32'h0);
    check_eq("rmid_wdata", 32'(w_mem_wdata), 32'h0);
    check_eq("rmid_io", w_io_regs, 32'h0);
    check_eq("rmid_io_main", io_regs, 32'h0);

    // Normal waited write after recovery
    snap();
    A = 16'h0055; dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    tick(6);
    bus_idle();
    tick(2);
    check_eq("post_we_w", 32'(n_we_w - b_we_w), 32'd1);
    check_eq("post_wait_w", 32'(n_wait_w - b_wait_w), 32'd3);
    check_eq("post_addr_w", 32'(w_mem_addr), 32'h0055);
    check_eq("post_wdata_w", 32'(w_mem_wdata), 32'h99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
